// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, one-entry skid buffer, redirect/flush.
// Optional FETCH_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, SKID, DROP} state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n, pc_inc;
    logic        valid_n;
    logic [31:0] instr_n, opc_n, opc4_n;
    logic [31:0] skid_instr, skid_pc, skid_instr_n, skid_pc_n;
    logic        slot_free;
    logic        load;

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = pc;
    assign pc_inc    = pc + 32'd4;
    assign slot_free = !if_valid || !stall;

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        valid_n      = if_valid;
        instr_n      = if_instr;
        opc_n        = if_pc;
        opc4_n       = if_pc4;
        skid_instr_n = skid_instr;
        skid_pc_n    = skid_pc;
        load         = 1'b0;
        if (redirect) begin
            // Masking keeps all redirect_pc bits in use while forcing word alignment.
            pc_n         = redirect_pc & ~32'h0000_0003;
            valid_n      = 1'b0;
            skid_instr_n = '0;
            skid_pc_n    = '0;
            if ((state == REQ || state == DROP) && !imem_ack)
                state_n = DROP;
            else
                state_n = REQ;
        end else begin
            case (state)
                IDLE: state_n = REQ;
                REQ: begin
                    if (imem_ack) begin
                        pc_n = pc_inc;
                        if (slot_free) begin
                            load    = 1'b1;
                            valid_n = 1'b1;
                            instr_n = imem_rdata;
                            opc_n   = pc;
                            opc4_n  = pc_inc;
                        end else begin
                            skid_instr_n = imem_rdata;
                            skid_pc_n    = pc;
                            state_n      = SKID;
                        end
                    end else if (slot_free) begin
                        valid_n = 1'b0;
                    end
                end
                SKID: begin
                    if (!stall) begin
                        load    = 1'b1;
                        valid_n = 1'b1;
                        instr_n = skid_instr;
                        opc_n   = skid_pc;
                        opc4_n  = skid_pc + 32'd4;
                        state_n = REQ;
                    end
                end
                DROP: if (imem_ack) state_n = REQ;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
            if_pc4     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            if_valid   <= valid_n;
            if_instr   <= instr_n;
            if_pc      <= opc_n;
            if_pc4     <= opc4_n;
            skid_instr <= skid_instr_n;
            skid_pc    <= skid_pc_n;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (load)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall && if_valid)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: checks the consumed instruction stream against
// program order, plus flush/hold/handshake rules and optional perf counters.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4)
`ifdef FETCH_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference state: program-order PC of the next instruction decode should see,
    // and a memory that answers for the address latched when a request began.
    logic [31:0] exp_pc;
    bit          mem_busy;
    logic [31:0] mem_lat;
    int unsigned consumed;
    bit          prev_redir, prev_hold, prev_wait, prev_skidfill, prev_cand;
    logic [31:0] prev_target, prev_pc, prev_instr, prev_addr;
    logic [31:0] exp_fetch, exp_stall;

    task automatic clear_model();
        exp_pc        = RESET_PC;
        mem_busy      = 0;
        mem_lat       = '0;
        prev_redir    = 0;
        prev_hold     = 0;
        prev_wait     = 0;
        prev_skidfill = 0;
        prev_cand     = 0;
        prev_target   = '0;
        prev_pc       = '0;
        prev_instr    = '0;
        prev_addr     = '0;
        exp_fetch     = '0;
        exp_stall     = '0;
    endtask

    task automatic reset_dut();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        repeat (2) @(negedge clk);
        check("rst_req",   {31'd0, imem_req}, 32'd0);
        check("rst_addr",  imem_addr, RESET_PC);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, 32'd0);
        check("rst_pc",    if_pc, 32'd0);
        check("rst_pc4",   if_pc4, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        reset = 1'b0;
        clear_model();
        // First cycle after release is IDLE: no request yet.
        check("idle_noreq", {31'd0, imem_req}, 32'd0);
    endtask

    // One clock: entered and left at a negedge. Percentages control the stimulus mix.
    task automatic cycle(input int unsigned p_ack, input int unsigned p_stall,
                         input int unsigned p_redir, input bit force_redir,
                         input logic [31:0] tgt);
        logic [31:0] t;
        if (prev_redir) begin
            check("flush_valid", {31'd0, if_valid}, 32'd0);
            check("redir_addr", imem_addr, prev_target);
        end
        if (prev_hold) begin
            check("hold_valid", {31'd0, if_valid}, 32'd1);
            check("hold_pc", if_pc, prev_pc);
            check("hold_instr", if_instr, prev_instr);
        end
        if (prev_wait) check("addr_stable", imem_addr, prev_addr);
        if (prev_skidfill) check("skid_noreq", {31'd0, imem_req}, 32'd0);
        check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
        if (prev_cand && if_valid) exp_fetch++;
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetch", perf_fetch_cnt, exp_fetch);
        check("perf_stall", perf_stall_cnt, exp_stall);
`endif

        stall    = ($urandom_range(99) < p_stall);
        redirect = force_redir || ($urandom_range(99) < p_redir);
        if (force_redir) t = tgt;
        else if ($urandom_range(9) == 0) t = 32'hFFFF_FFF0 | {28'd0, 4'($urandom)};
        else t = {20'd0, 12'($urandom)};
        redirect_pc = t;

        if (imem_req) begin
            if (!mem_busy) begin
                mem_lat  = imem_addr;
                mem_busy = 1;
            end
            imem_ack   = ($urandom_range(99) < p_ack);
            imem_rdata = imem_ack ? (mem_lat ^ KEY) : $urandom;
        end else begin
            imem_ack   = $urandom_range(1) == 1;
            imem_rdata = $urandom;
        end

        if (if_valid && !stall && !redirect) begin
            check("pc", if_pc, exp_pc);
            check("instr", if_instr, exp_pc ^ KEY);
            check("pc4", if_pc4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (redirect) exp_pc = {t[31:2], 2'b00};
        if (if_valid && stall) exp_stall++;

        prev_redir    = redirect;
        prev_target   = {t[31:2], 2'b00};
        prev_hold     = if_valid && stall && !redirect;
        prev_pc       = if_pc;
        prev_instr    = if_instr;
        prev_wait     = imem_req && !imem_ack && !redirect;
        prev_addr     = imem_addr;
        prev_skidfill = if_valid && stall && imem_req && imem_ack && !redirect;
        prev_cand     = (!if_valid || !stall) && !redirect;
        if (imem_req && imem_ack) mem_busy = 0;

        @(negedge clk);
    endtask

    initial begin
        consumed = 0;
        clear_model();
        @(negedge clk);
        reset_dut();

        // Streaming with ack tied high; request must appear in the second cycle.
        cycle(100, 0, 0, 0, '0);
        check("req_cycle2", {31'd0, imem_req}, 32'd1);
        repeat (4) cycle(100, 0, 0, 0, '0);
        // Back-pressure for 3 cycles, then release.
        repeat (3) cycle(100, 100, 0, 0, '0);
        repeat (5) cycle(100, 0, 0, 0, '0);

        // Redirect while a request is pending, abandoned data arrives two cycles later.
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 1, 32'h0000_0100);
        cycle(0, 0, 0, 0, '0);
        repeat (6) cycle(100, 0, 0, 0, '0);

        // Unaligned redirect target and PC wrap-around.
        cycle(100, 0, 0, 1, 32'h0000_0203);
        repeat (3) cycle(100, 0, 0, 0, '0);
        cycle(100, 0, 0, 1, 32'hFFFF_FFF8);
        repeat (6) cycle(100, 0, 0, 0, '0);

        // Randomized traffic with a mid-run reset.
        repeat (800) cycle(60, 30, 5, 0, '0);
        reset_dut();
        repeat (800) cycle(70, 25, 4, 0, '0);

        check("progress", {31'd0, consumed >= 300}, 32'd1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 32-bit MIPS pipeline: holds the program counter, issues requests to instruction memory under a req/ack handshake, and delivers instruction, PC and PC+4 into the IF/ID pipeline register bank. It handles decode back-pressure via a one-entry skid buffer and applies branch/jump redirects with flush. It sits directly upstream of the 32-bit pipeline registers feeding decode.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  memory response valid; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- stall  in  1  decode cannot accept; output held when stall=1 and if_valid=1
- redirect  in  1  branch/jump taken; highest priority
- redirect_pc  in  32  new PC; bits [1:0] forced to 0 internally
- if_valid  out  1  if_instr/if_pc/if_pc4 hold a live instruction
- if_instr  out  32  fetched instruction
- if_pc  out  32  address of if_instr
- if_pc4  out  32  if_pc + 4

## Operation
- States: IDLE, REQ, SKID, DROP. Reset -> IDLE. IDLE -> REQ unconditionally.
- imem_req = 1 in REQ and DROP, else 0. imem_addr = pc; held stable while imem_req=1 until ack.
- Consume: output slot is free at an edge if if_valid=0 or stall=0.
- REQ, ack, no redirect: slot free -> load output {imem_rdata, pc, pc+4}, if_valid=1, pc<=pc+4, stay REQ; slot not free -> write skid, pc<=pc+4, go SKID.
- REQ, no ack: if slot free, if_valid<=0; stay REQ.
- SKID: imem_req=0. stall=0 at edge -> skid moves to output (if_valid stays 1), go REQ. stall=1 -> hold.
- DROP: waiting for ack of an abandoned request. On ack, data discarded, go REQ. No output load.
- Redirect (any state, overrides all above): pc<={redirect_pc[31:2],2'b00}; if_valid<=0; skid cleared. From REQ without same-cycle ack -> DROP; from REQ with same-cycle ack -> data discarded, REQ; from IDLE/SKID/DROP-with-ack -> REQ; DROP without ack -> stays DROP.
- PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000; if_pc4 wraps identically.
- stall with if_valid=0 has no effect.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr=0 (NOP), if_pc=0, if_pc4=0, skid empty, state IDLE.
- First imem_req=1 in the second cycle after reset deasserts (IDLE cycle first).
- Ack-to-if_valid latency: 1 cycle (registered outputs).
- Same-cycle ack: one instruction per cycle sustained while stall=0.
- Redirect: if_valid=0 the cycle after; first request to redirect_pc on that same cycle if no DROP; otherwise the cycle after the pending ack.
- Reset mid-request: outstanding request abandoned; memory side must tolerate req dropping on reset only.

## Configuration
- FETCH_PERF_CNT_EN defined: adds outputs perf_fetch_cnt (32, increments on each instruction loaded into output, skid included once) and perf_stall_cnt (32, increments each cycle stall=1 and if_valid=1); both reset to 0, wrap modulo 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset release, RESET_PC=0, ack tied 1, rdata=addr^32'hA5A5_A5A5 -> req rises cycle 2; if_pc 0,4,8,... one per cycle, if_instr matches.
- stall=1 for 3 cycles at if_pc=8 with ack=1 -> if_pc stays 8, instr 12 in skid, req=0; stall drops -> if_pc 12 next, then 16, no loss/duplication.
- Redirect to 32'h0000_0100 while req pending, ack 2 cycles later with junk -> if_valid=0, junk dropped, next if_pc=0x100.
- redirect_pc=32'h0000_0203 -> next fetch address 0x200.
- pc=32'hFFFF_FFFC fetched -> if_pc4=0, next imem_addr=0.
- With FETCH_PERF_CNT_EN: 10 fetches, 4 stalled-valid cycles -> perf_fetch_cnt=10, perf_stall_cnt=4; reset mid-run -> both 0.
